door_lock_controller: RTL and testbench

- Sequencing controller for the keypad door lock.
- Collects multi-digit key entries, compares them against a stored, reprogrammable code and drives the unlock/error outputs.
- Enforces a lockout after repeated failures, and an inter-key timeout.
- Sits between the keypad scanner/debouncer (Key, Key_Valid) and the lock actuator and status LEDs.

---
 rtl/door_lock_controller_if.sv | 33 +++
 rtl/door_lock_controller.sv | 197 +++++++++++++++++++
 tb/tb_door_lock_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/door_lock_controller_if.sv
// Keypad-side and lock-side signal bundle for the door lock controller.
// Latency: none, wiring only.
// Backpressure: none; Key_Valid is a single-cycle strobe that the controller accepts or drops.
interface door_lock_controller_if #(
    parameter int CODE_LEN  = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 3
);
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    logic [DIGIT_W-1:0] Key;
    logic               Key_Valid;
    logic               Prog_Req;
    logic               Unlock;
    logic               Err;
    logic               Locked_Out;
    logic               Prog_Active;
    logic [CNT_W-1:0]   Digit_Cnt;
    logic [FAIL_W-1:0]  Fail_Cnt;

    // Keypad / supervisor side: drives keys and programming requests, watches status.
    modport master (
        output Key, Key_Valid, Prog_Req,
        input  Unlock, Err, Locked_Out, Prog_Active, Digit_Cnt, Fail_Cnt
    );

    // Controller side.
    modport slave (
        input  Key, Key_Valid, Prog_Req,
        output Unlock, Err, Locked_Out, Prog_Active, Digit_Cnt, Fail_Cnt
    );
endinterface

// File: rtl/door_lock_controller.sv
// Keypad door lock sequencer: collects digits, checks/reprograms the code, unlock, lockout, timeout.
// Latency: final digit sampled at edge N -> CHECK in cycle N+1 -> Unlock or Err in cycle N+2.
// Backpressure: none; Key_Valid outside IDLE/ENTRY/PROG is dropped, never queued.
module door_lock_controller #(
    parameter int                            CODE_LEN       = 4,
    parameter int                            DIGIT_W        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
    parameter int                            OPEN_CYCLES    = 8,
    parameter int                            MAX_TRIES      = 3,
    parameter int                            LOCKOUT_CYCLES = 16,
    parameter int                            TIMEOUT_CYCLES = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    door_lock_controller_if.slave bus
);
    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int TMAX0  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX   = (TIMEOUT_CYCLES > TMAX0) ? TIMEOUT_CYCLES : TMAX0;
    localparam int TMR_W  = $clog2(TMAX + 1);

    // Terminal values: a phase ends on the edge where its timer already shows "last cycle".
    localparam logic [TMR_W-1:0]  TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CODE_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CODE_LEN);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_TRIES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        PROG    = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    state_t              state;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-1:0]   entry_buf;
    logic [CODE_W-1:0]   entry_next;
    logic [CNT_W-1:0]    digit_cnt;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [TMR_W-1:0]    timer;
    logic                unlock;
    logic                err;
    logic                locked_out;
    logic                prog_active;

    // Entry buffer with the incoming digit written into the slot selected by the digit count,
    // so the first digit of a sequence lands in the most-significant position.
    always_comb begin
        entry_next = entry_buf;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (digit_cnt == CNT_W'(CODE_LEN - 1 - i)) begin
                entry_next[i*DIGIT_W +: DIGIT_W] = bus.Key;
            end
        end
    end

    // Main sequencer: state, stored code, counters, timer and all registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            code        <= DEFAULT_CODE;
            entry_buf   <= '0;
            digit_cnt   <= '0;
            fail_cnt    <= '0;
            timer       <= '0;
            unlock      <= 1'b0;
            err         <= 1'b0;
            locked_out  <= 1'b0;
            prog_active <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (bus.Key_Valid) begin
                        entry_buf <= entry_next;
                        digit_cnt <= CNT_W'(1);
                        state     <= ENTRY;
                    end
                end

                ENTRY: begin
                    if (bus.Key_Valid) begin
                        // A strobe on the timeout edge still counts as a digit.
                        entry_buf <= entry_next;
                        timer     <= '0;
                        if (digit_cnt == CNT_LAST) begin
                            digit_cnt <= CNT_FULL;
                            state     <= CHECK;
                        end else begin
                            digit_cnt <= digit_cnt + CNT_W'(1);
                        end
                    end else if (timer == TMO_LAST) begin
                        digit_cnt <= '0;
                        timer     <= '0;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                CHECK: begin
                    digit_cnt <= '0;
                    timer     <= '0;
                    if (entry_buf == code) begin
                        fail_cnt <= '0;
                        unlock   <= 1'b1;
                        state    <= OPEN;
                    end else begin
                        err      <= 1'b1;
                        fail_cnt <= fail_cnt + FAIL_W'(1);
                        if (fail_cnt == FAIL_LAST) begin
                            locked_out <= 1'b1;
                            state      <= LOCKOUT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                OPEN: begin
                    // A programming request beats the normal expiry, even on the last cycle.
                    if (bus.Prog_Req) begin
                        unlock      <= 1'b0;
                        prog_active <= 1'b1;
                        digit_cnt   <= '0;
                        timer       <= '0;
                        state       <= PROG;
                    end else if (timer == OPEN_LAST) begin
                        unlock <= 1'b0;
                        timer  <= '0;
                        state  <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                PROG: begin
                    if (bus.Key_Valid) begin
                        entry_buf <= entry_next;
                        timer     <= '0;
                        if (digit_cnt == CNT_LAST) begin
                            code        <= entry_next;
                            digit_cnt   <= '0;
                            prog_active <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            digit_cnt <= digit_cnt + CNT_W'(1);
                        end
                    end else if (timer == TMO_LAST) begin
                        // Abandoned programming leaves the stored code untouched.
                        digit_cnt   <= '0;
                        timer       <= '0;
                        prog_active <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                LOCKOUT: begin
                    if (timer == LOCK_LAST) begin
                        fail_cnt   <= '0;
                        locked_out <= 1'b0;
                        timer      <= '0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                default: begin
                    state       <= IDLE;
                    digit_cnt   <= '0;
                    timer       <= '0;
                    unlock      <= 1'b0;
                    locked_out  <= 1'b0;
                    prog_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Unlock      = unlock;
    assign bus.Err         = err;
    assign bus.Locked_Out  = locked_out;
    assign bus.Prog_Active = prog_active;
    assign bus.Digit_Cnt   = digit_cnt;
    assign bus.Fail_Cnt    = fail_cnt;
endmodule

// File: tb/tb_door_lock_controller.sv
// Bench for door_lock_controller: directed scenarios plus randomized attempts vs. a code/attempt model.
// Latency: checks Unlock/Err two cycles after the last key strobe.
// Backpressure: drives key strobes during CHECK/OPEN/LOCKOUT to confirm they are dropped.
module tb_door_lock_controller;
    logic Clk;
    logic Rst_n;

    int checks = 0;
    int errors = 0;

    // Reference model state: the code the lock should hold and its consecutive failure count.
    logic [15:0] ref_code = 16'h1234;
    int          ref_fail = 0;

    localparam int OPEN_N = 8;
    localparam int LOCK_N = 16;
    localparam int TMO_N  = 32;
    localparam int TRIES  = 3;

    door_lock_controller_if #(.CODE_LEN(4), .DIGIT_W(4), .MAX_TRIES(3)) bus ();

    door_lock_controller #(
        .CODE_LEN(4), .DIGIT_W(4), .DEFAULT_CODE(16'h1234), .OPEN_CYCLES(8),
        .MAX_TRIES(3), .LOCKOUT_CYCLES(16), .TIMEOUT_CYCLES(32)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; afterwards outputs are stable and new inputs land before the next edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.Key_Valid = 1'b0;
        bus.Prog_Req  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic press(input logic [3:0] d);
        bus.Key       = d;
        bus.Key_Valid = 1'b1;
        tick();
        bus.Key_Valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_unlock"}, bus.Unlock, 0);
        check({tag, "_err"}, bus.Err, 0);
        check({tag, "_locked"}, bus.Locked_Out, 0);
        check({tag, "_prog"}, bus.Prog_Active, 0);
        check({tag, "_dcnt"}, bus.Digit_Cnt, 0);
        check({tag, "_fcnt"}, bus.Fail_Cnt, 0);
    endtask

    // One full code entry, followed through its whole consequence (open, error or lockout).
    task automatic attempt(input logic [15:0] c, input int gap, input bit noise, input string tag);
        bit ok;
        for (int d = 3; d >= 0; d--) begin
            press(c[d*4 +: 4]);
            if (d != 0) idle(gap);
        end
        check({tag, "_dcnt_full"}, bus.Digit_Cnt, 4);
        check({tag, "_chk_unlock"}, bus.Unlock, 0);
        ok = (c == ref_code);
        if (noise) begin
            bus.Key       = 4'($urandom);
            bus.Key_Valid = 1'($urandom);
        end
        tick();
        bus.Key_Valid = 1'b0;
        if (ok) begin
            ref_fail = 0;
            check({tag, "_unlock"}, bus.Unlock, 1);
            check({tag, "_err"}, bus.Err, 0);
            check({tag, "_fcnt"}, bus.Fail_Cnt, 0);
            for (int i = 2; i <= OPEN_N; i++) begin
                if (noise) begin
                    bus.Key       = 4'($urandom);
                    bus.Key_Valid = 1'($urandom);
                end
                tick();
                check({tag, "_open_hold"}, bus.Unlock, 1);
            end
            bus.Key_Valid = 1'b0;
            tick();
            check({tag, "_open_end"}, bus.Unlock, 0);
            check({tag, "_open_end_dcnt"}, bus.Digit_Cnt, 0);
        end else begin
            ref_fail++;
            check({tag, "_err"}, bus.Err, 1);
            check({tag, "_unlock"}, bus.Unlock, 0);
            check({tag, "_fcnt"}, bus.Fail_Cnt, 32'(ref_fail));
            if (ref_fail == TRIES) begin
                check({tag, "_locked"}, bus.Locked_Out, 1);
                for (int i = 2; i <= LOCK_N; i++) begin
                    if (i <= 5) begin
                        bus.Key       = 4'(i - 1);
                        bus.Key_Valid = 1'b1;
                    end else if (noise) begin
                        bus.Key       = 4'($urandom);
                        bus.Key_Valid = 1'($urandom);
                    end else begin
                        bus.Key_Valid = 1'b0;
                    end
                    tick();
                    check({tag, "_lock_hold"}, bus.Locked_Out, 1);
                    check({tag, "_lock_nounlock"}, bus.Unlock, 0);
                    check({tag, "_lock_noerr"}, bus.Err, 0);
                end
                bus.Key_Valid = 1'b0;
                tick();
                ref_fail = 0;
                check({tag, "_lock_end"}, bus.Locked_Out, 0);
                check({tag, "_lock_end_fcnt"}, bus.Fail_Cnt, 0);
                check({tag, "_lock_end_dcnt"}, bus.Digit_Cnt, 0);
            end else begin
                tick();
                check({tag, "_err_pulse"}, bus.Err, 0);
                check({tag, "_nolock"}, bus.Locked_Out, 0);
                check({tag, "_after_unlock"}, bus.Unlock, 0);
            end
        end
    endtask

    initial begin
        bus.Key       = '0;
        bus.Key_Valid = 1'b0;
        bus.Prog_Req  = 1'b0;
        Rst_n         = 1'b0;
        #2;
        check_all_zero("reset_hold");
        repeat (3) tick();
        Rst_n = 1'b1;
        tick();
        check_all_zero("reset_rel");

        // Correct code, then a wrong one.
        attempt(16'h1234, 0, 1'b0, "correct");
        attempt(16'h1235, 0, 1'b0, "wrong");

        // Inter-key timeout: 31 idle cycles keep the entry, the 32nd aborts it.
        press(4'h1);
        press(4'h2);
        check("tmo_dcnt2", bus.Digit_Cnt, 2);
        idle(TMO_N - 1);
        check("tmo_edge_minus1", bus.Digit_Cnt, 2);
        idle(1);
        check("tmo_dcnt0", bus.Digit_Cnt, 0);
        check("tmo_err", bus.Err, 0);
        check("tmo_fcnt", bus.Fail_Cnt, 32'(ref_fail));

        // Key on the very edge the timeout would fire is accepted.
        press(4'h7);
        idle(TMO_N - 1);
        press(4'h8);
        check("tmo_race_dcnt", bus.Digit_Cnt, 2);
        idle(TMO_N);
        check("tmo_race_abort", bus.Digit_Cnt, 0);

        // Recovery after one failure.
        attempt(16'h1234, 1, 1'b0, "recover");

        // Three failures back-to-back trigger lockout; correct code works afterwards.
        attempt(16'h1111, 0, 1'b0, "lk1");
        attempt(16'h2222, 0, 1'b0, "lk2");
        attempt(16'h3333, 0, 1'b0, "lk3");
        attempt(16'h1234, 0, 1'b0, "post_lock");

        // Reprogram: Prog_Req in the third OPEN cycle, new code 9876.
        for (int d = 3; d >= 0; d--) press(ref_code[d*4 +: 4]);
        ref_fail = 0;
        tick();
        check("prog_open1", bus.Unlock, 1);
        tick();
        tick();
        check("prog_open3", bus.Unlock, 1);
        bus.Prog_Req = 1'b1;
        tick();
        bus.Prog_Req = 1'b0;
        check("prog_active", bus.Prog_Active, 1);
        check("prog_unlock_drop", bus.Unlock, 0);
        press(4'h9);
        check("prog_dcnt1", bus.Digit_Cnt, 1);
        press(4'h8);
        press(4'h7);
        check("prog_mid", bus.Prog_Active, 1);
        check("prog_dcnt3", bus.Digit_Cnt, 3);
        press(4'h6);
        check("prog_done", bus.Prog_Active, 0);
        check("prog_done_err", bus.Err, 0);
        check("prog_done_unlock", bus.Unlock, 0);
        check("prog_done_dcnt", bus.Digit_Cnt, 0);
        ref_code = 16'h9876;
        tick();
        attempt(16'h1234, 0, 1'b0, "old_code");
        attempt(16'h9876, 0, 1'b0, "new_code");

        // Randomized attempts with gaps, stray strobes and aborted partial entries.
        for (int n = 0; n < 25; n++) begin
            logic [15:0] c;
            if ($urandom_range(0, 4) == 0) begin
                int k;
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) begin
                    press(4'($urandom));
                    idle($urandom_range(0, 3));
                end
                check("rnd_part_dcnt", bus.Digit_Cnt, 32'(k));
                idle(TMO_N);
                check("rnd_part_abort", bus.Digit_Cnt, 0);
                check("rnd_part_fcnt", bus.Fail_Cnt, 32'(ref_fail));
            end
            c = ($urandom_range(0, 1) == 1) ? ref_code : 16'($urandom);
            attempt(c, $urandom_range(0, 4), 1'b1, "rnd");
        end

        // Reset in the middle of programming: outputs clear at once, default code returns.
        for (int d = 3; d >= 0; d--) press(ref_code[d*4 +: 4]);
        ref_fail = 0;
        tick();
        bus.Prog_Req = 1'b1;
        tick();
        bus.Prog_Req = 1'b0;
        check("rstprog_active", bus.Prog_Active, 1);
        press(4'h5);
        press(4'h5);
        check("rstprog_dcnt", bus.Digit_Cnt, 2);
        Rst_n = 1'b0;
        #2;
        check_all_zero("rstprog");
        #2;
        Rst_n = 1'b1;
        ref_code = 16'h1234;
        ref_fail = 0;
        tick();
        attempt(16'h9876, 0, 1'b0, "rst_oldprog");
        attempt(16'h1234, 0, 1'b0, "rst_default");

        // Reset while open: Unlock drops without waiting for a clock.
        for (int d = 3; d >= 0; d--) press(ref_code[d*4 +: 4]);
        tick();
        check("rstopen_unlock", bus.Unlock, 1);
        Rst_n = 1'b0;
        #2;
        check("rstopen_async", bus.Unlock, 0);
        #2;
        Rst_n = 1'b1;
        tick();
        check_all_zero("rstopen_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
